spell_mem_requester: RTL and testbench

- Initiator side of the SPELL select/data_ready memory handshake. Drives the internal code/data memory responder on behalf of the core.
- Core side: one request at a time through a valid/ready handshake. Request fields are latched, then driven to the memory until it reports ready. Read data is captured and returned as a one-cycle response.
- A watchdog aborts accesses the memory never completes.

---
 rtl/spell_mem_pkg.sv | 17 +
 rtl/spell_mem_watchdog.sv | 29 ++
 rtl/spell_mem_requester.sv | 103 ++++++++++
 tb/tb_spell_mem_requester.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_mem_pkg.sv
// Shared definitions for the SPELL memory requester: state encoding and memory constants.
package spell_mem_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StRelease = 2'd2
  } state_t;

  // Values returned when an access times out, mimicking an unmapped location.
  localparam logic [7:0] MEM_DATA_DEFAULT = 8'h00;
  localparam logic [7:0] MEM_CODE_DEFAULT = 8'hff;

  localparam int unsigned CODE_SIZE = 32;
  localparam int unsigned DATA_SIZE = 8;

endpackage

// File: rtl/spell_mem_watchdog.sv
// Clear/enable saturating cycle counter; expired flags the last allowed wait cycle.
module spell_mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A zero timeout disables the watchdog entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_TERM);

endmodule

// File: rtl/spell_mem_requester.sv
// Initiator side of the SPELL select/data_ready handshake: one core request at a time,
// registered memory drive, one-cycle response, watchdog abort.
module spell_mem_requester
  import spell_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic                  req_type_data,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  mem_select,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_type_data,
  output logic                  mem_write,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_data_ready
);

  state_t state_q;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_expired;

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign wd_clr    = (state_q == StIdle) && req_valid;
  assign wd_en     = (state_q == StAccess) && !mem_data_ready;

  spell_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      mem_select    <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 8'h00;
      mem_type_data <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_rdata     <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mem_addr      <= req_addr;
            mem_write     <= req_write;
            mem_type_data <= req_type_data;
            mem_wdata     <= req_wdata;
            mem_select    <= 1'b1;
            state_q       <= StAccess;
          end
        end
        StAccess: begin
          // Ready takes priority over a timeout landing on the same edge.
          if (mem_data_ready) begin
            rsp_rdata  <= mem_write ? 8'h00 : mem_rdata;
            rsp_valid  <= 1'b1;
            mem_select <= 1'b0;
            mem_write  <= 1'b0;
            state_q    <= StRelease;
          end else if (wd_expired) begin
            rsp_rdata  <= mem_type_data ? MEM_DATA_DEFAULT : MEM_CODE_DEFAULT;
            rsp_valid  <= 1'b1;
            rsp_error  <= 1'b1;
            mem_select <= 1'b0;
            mem_write  <= 1'b0;
            state_q    <= StRelease;
          end
        end
        StRelease: begin
          // Wait out the responder's stale ready before allowing a new select.
          if (!mem_data_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spell_mem_requester.sv
// Directed bench for spell_mem_requester with a configurable responder and a response model.
module tb_spell_mem_requester;
  import spell_mem_pkg::*;

  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic          req_type_data = 1'b0;
  logic [7:0]    req_wdata = 8'h00;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          rsp_error;
  logic          busy;
  logic          mem_select;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_type_data;
  logic          mem_write;
  logic [7:0]    mem_rdata;
  logic          mem_data_ready;

  spell_mem_requester #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_write     (req_write),
    .req_type_data (req_type_data),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .busy          (busy),
    .mem_select    (mem_select),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_type_data (mem_type_data),
    .mem_write     (mem_write),
    .mem_rdata     (mem_rdata),
    .mem_data_ready(mem_data_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- responder ----------------
  int   r_wait_cfg = 0;
  int   r_hold_cfg = 0;
  bit   r_never    = 1'b0;
  logic force_ready = 1'b0;
  logic r_ready = 1'b0;
  logic [7:0] r_rdata = 8'h00;
  int   r_wcnt = 0;
  int   r_hcnt = 0;
  bit   r_inited = 1'b0;
  logic [7:0] r_code [CODE_SIZE];
  logic [7:0] r_data [DATA_SIZE];

  assign mem_data_ready = r_ready | force_ready;
  assign mem_rdata      = r_rdata;

  always @(posedge clk) begin
    if (!r_inited) begin
      for (int i = 0; i < CODE_SIZE; i++) r_code[i] <= 8'(i * 12);
      for (int i = 0; i < DATA_SIZE; i++) r_data[i] <= 8'(i * 17 + 1);
      r_inited <= 1'b1;
    end else if (mem_select) begin
      r_hcnt <= 0;
      if (!r_ready && !r_never) begin
        if (r_wcnt >= r_wait_cfg) begin
          r_ready <= 1'b1;
          if (mem_write) begin
            r_rdata <= 8'h00;
            if (mem_type_data) r_data[mem_addr[2:0]] <= mem_wdata;
            else               r_code[mem_addr[4:0]] <= mem_wdata;
          end else begin
            r_rdata <= mem_type_data ? r_data[mem_addr[2:0]] : r_code[mem_addr[4:0]];
          end
        end else begin
          r_wcnt <= r_wcnt + 1;
        end
      end
    end else begin
      r_wcnt <= 0;
      if (r_ready && (r_hcnt < r_hold_cfg)) begin
        r_hcnt <= r_hcnt + 1;
      end else begin
        r_ready <= 1'b0;
        r_hcnt  <= 0;
      end
    end
  end

  // ---------------- response model ----------------
  typedef struct packed {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_code [CODE_SIZE];
  logic [7:0] m_data [DATA_SIZE];
  logic [AW-1:0] cur_addr = '0;
  logic          cur_write = 1'b0;
  logic [7:0]    cur_wdata = 8'h00;
  bit            chk_en = 1'b0;

  // Completion latency is 2 + responder waits; beyond the timeout the access aborts.
  function automatic void model_push(input logic [7:0] a, input logic w, input logic t,
                                     input logic [7:0] wd);
    exp_t e;
    bit   tmo;
    tmo = r_never || (r_wait_cfg + 2 > TO);
    if (tmo) begin
      e.err = 1'b1;
      e.rd  = t ? 8'h00 : 8'hff;
    end else begin
      e.err = 1'b0;
      if (w) begin
        e.rd = 8'h00;
        if (t) m_data[a[2:0]] = wd;
        else   m_code[a[4:0]] = wd;
      end else begin
        e.rd = t ? m_data[a[2:0]] : m_code[a[4:0]];
      end
    end
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_vs_ready", int'(busy), int'(!req_ready));
      if (rsp_valid) begin
        chk("rsp_deselected", int'(mem_select), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("model_rdata", int'(rsp_rdata), int'(e.rd));
          chk("model_error", int'(rsp_error), int'(e.err));
        end
      end
      if (mem_select) begin
        chk("stable_addr", int'(mem_addr), int'(cur_addr));
        chk("stable_write", int'(mem_write), int'(cur_write));
        chk("stable_wdata", int'(mem_wdata), int'(cur_wdata));
      end
    end
  end

  // ---------------- directed driver ----------------
  task automatic start_req(input logic [7:0] a, input logic w, input logic t,
                           input logic [7:0] wd, input bit expect_rsp, output int acc_cyc);
    int i;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_type_data = t; req_wdata = wd;
    for (i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cur_addr  = a; cur_write = w; cur_wdata = wd;
    if (expect_rsp) model_push(a, w, t, wd);
    // Core is free to scramble the request after the handshake.
    req_valid = 1'b0; req_addr = ~a; req_write = ~w; req_type_data = ~t; req_wdata = ~wd;
  endtask

  task automatic do_req(input string nm, input logic [7:0] a, input logic w, input logic t,
                        input logic [7:0] wd, input int exp_lat, input int exp_idle,
                        input logic [7:0] exp_rd, input logic exp_err);
    int acc_cyc, rsp_cyc;
    bit got;
    start_req(a, w, t, wd, 1'b1, acc_cyc);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_got_rsp"}, int'(got), 1);
    rsp_cyc = cyc;
    chk({nm, "_lat"}, rsp_cyc - acc_cyc, exp_lat);
    chk({nm, "_rdata"}, int'(rsp_rdata), int'(exp_rd));
    chk({nm, "_err"}, int'(rsp_error), int'(exp_err));
    for (int i = 0; i < 60 && !req_ready; i++) @(negedge clk);
    chk({nm, "_idle_lat"}, cyc - rsp_cyc, exp_idle);
  endtask

  initial begin
    int acc_cyc;
    for (int i = 0; i < CODE_SIZE; i++) m_code[i] = 8'(i * 12);
    for (int i = 0; i < DATA_SIZE; i++) m_data[i] = 8'(i * 17 + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_select", int'(mem_select), 0);
    chk("rst_write", int'(mem_write), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_type", int'(mem_type_data), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_error", int'(rsp_error), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_req("code_rd5", 8'd5, 1'b0, 1'b0, 8'h00, 2, 2, 8'h3c, 1'b0);
    do_req("data_wr3", 8'd3, 1'b1, 1'b1, 8'ha5, 2, 2, 8'h00, 1'b0);
    do_req("data_rd3", 8'd3, 1'b0, 1'b1, 8'h00, 2, 2, 8'ha5, 1'b0);

    r_wait_cfg = 3;
    do_req("wait3_rd9", 8'd9, 1'b0, 1'b0, 8'h00, 5, 2, 8'h6c, 1'b0);
    do_req("wait3_wr6", 8'd6, 1'b1, 1'b1, 8'h5a, 5, 2, 8'h00, 1'b0);
    r_wait_cfg = 0;
    do_req("data_rd6", 8'd6, 1'b0, 1'b1, 8'h00, 2, 2, 8'h5a, 1'b0);

    r_never = 1'b1;
    do_req("tmo_code", 8'd2, 1'b0, 1'b0, 8'h00, 15, 1, 8'hff, 1'b1);
    do_req("tmo_data", 8'd1, 1'b0, 1'b1, 8'h00, 15, 1, 8'h00, 1'b1);
    r_never = 1'b0;

    // Ready landing exactly on the terminal count wins; one cycle later is too late.
    r_wait_cfg = 13;
    do_req("edge_ready", 8'd7, 1'b0, 1'b0, 8'h00, 15, 2, 8'h54, 1'b0);
    r_wait_cfg = 14;
    do_req("edge_tmo", 8'd7, 1'b0, 1'b0, 8'h00, 15, 2, 8'hff, 1'b1);
    r_wait_cfg = 0;

    r_hold_cfg = 3;
    do_req("hold3", 8'd5, 1'b0, 1'b0, 8'h00, 2, 5, 8'h3c, 1'b0);
    r_hold_cfg = 0;

    force_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_busy", int'(busy), 0);
      chk("idle_ready_rsp", int'(rsp_valid), 0);
    end
    force_ready = 1'b0;
    do_req("after_force", 8'd4, 1'b0, 1'b1, 8'h00, 2, 2, 8'h45, 1'b0);

    r_never = 1'b1;
    start_req(8'd10, 1'b0, 1'b0, 8'h00, 1'b0, acc_cyc);
    repeat (3) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_select", int'(mem_select), 0);
    chk("mid_rst_rsp", int'(rsp_valid), 0);
    chk("mid_rst_idle", int'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    r_never = 1'b0;
    do_req("post_rst", 8'd3, 1'b0, 1'b1, 8'h00, 2, 2, 8'ha5, 1'b0);

    repeat (4) @(negedge clk);
    chk("pending_rsp", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
